// File: rtl/io16_spi_slave.sv
// SPI mode-0 register slave exposing 16 IO lines, with change interrupt.
// Latency: edges seen SYNC_STAGES+1 CLK after pins; write commits 1 CLK after 24th SCK rise.
// Backpressure: none; SPI master paces frames, CLK must be >= 8x SPI_CLK.
module io16_spi_slave #(
   parameter logic [15:0] ID_VALUE    = 16'h1016,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        SPI_CLK,
   input  logic        SPI_MOSI,
   input  logic        SPI_NSS,
   output logic        SPI_MISO,
   output logic        SPI_INT_N,
   input  logic [15:0] IO_IN,
   output logic [15:0] IO_OUT,
   output logic [15:0] IO_OE
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   state_t      state, state_nxt;
   logic [18:0] sync_q [SYNC_STAGES];
   logic        sck_s, mosi_s, nss_s;
   logic [15:0] in_s, in_prev;
   logic        sck_prev, nss_prev;
   logic        sck_rise, sck_fall, nss_fall;
   logic        cmd_end, frame_end;
   logic [4:0]  bit_cnt;
   logic [14:0] rx_sr;
   logic [7:0]  cmd_q;
   logic [15:0] tx_sr;
   logic [6:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] out_q, dir_q, ie_q, isr_q;
   logic        commit;
   logic [15:0] wdata, w1c;
   logic        int_n_q;

   // Oversample every asynchronous input through the same synchronizer depth
   always_ff @(posedge CLK) begin
      sync_q[0] <= {SPI_CLK, SPI_MOSI, SPI_NSS, IO_IN};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
   end

   assign {sck_s, mosi_s, nss_s, in_s} = sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign nss_fall = ~nss_s & nss_prev;

   // Edge history; loads current level in reset so reset exit creates no edge
   always_ff @(posedge CLK) begin
      sck_prev <= sck_s;
      nss_prev <= nss_s;
   end

   // Frame state register
   always_ff @(posedge CLK) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   // Frame sequencing; NSS high forces IDLE from anywhere, so aborted frames never commit
   always_comb begin
      state_nxt = state;
      cmd_end   = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: if (nss_fall) state_nxt = CMD;
         CMD:  if (sck_rise && bit_cnt == 5'd7) begin
                  cmd_end   = 1'b1;
                  state_nxt = DATA;
               end
         DATA: if (sck_rise && bit_cnt == 5'd23) begin
                  frame_end = 1'b1;
                  state_nxt = DONE;
               end
         DONE: state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (nss_s && state != IDLE) begin
         state_nxt = IDLE;
         cmd_end   = 1'b0;
         frame_end = 1'b0;
      end
   end

   assign rd_addr = {rx_sr[5:0], mosi_s};

   // Read mux addressed by the command byte as it completes
   always_comb begin
      rd_data = 16'h0000;
      case (rd_addr)
         7'h00: rd_data = out_q;
         7'h01: rd_data = dir_q;
         7'h02: rd_data = in_s;
         7'h03: rd_data = ie_q;
         7'h04: rd_data = isr_q;
         7'h05: rd_data = ID_VALUE;
         default: rd_data = 16'h0000;
      endcase
   end

   // Bit counter, RX shifter, command latch and TX shifter
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         bit_cnt <= '0;
         rx_sr   <= '0;
         cmd_q   <= '0;
         tx_sr   <= '0;
      end else begin
         if (state == IDLE && nss_fall) begin
            bit_cnt <= '0;
         end else if (sck_rise && (state == CMD || state == DATA)) begin
            bit_cnt <= bit_cnt + 5'd1;
            rx_sr   <= {rx_sr[13:0], mosi_s};
         end
         if (cmd_end) begin
            cmd_q <= {rx_sr[6:0], mosi_s};
            if (rx_sr[6]) tx_sr <= rd_data;
         end else if (sck_fall && state == DATA && bit_cnt >= 5'd9) begin
            // the fall after the 8th rise must keep bit 15 for the 9th rise
            tx_sr <= {tx_sr[14:0], 1'b0};
         end
      end
   end

   assign commit = frame_end & ~cmd_q[7];
   assign wdata  = {rx_sr[14:0], mosi_s};
   assign w1c    = (commit && cmd_q[6:0] == 7'h04) ? wdata : 16'h0000;

   // Register file and change detection; a fresh edge overrides a same-cycle clear
   always_ff @(posedge CLK) begin
      in_prev <= in_s;
      if (!RST_N) begin
         out_q <= '0;
         dir_q <= '0;
         ie_q  <= '0;
         isr_q <= '0;
      end else begin
         if (commit) begin
            case (cmd_q[6:0])
               7'h00: out_q <= wdata;
               7'h01: dir_q <= wdata;
               7'h03: ie_q  <= wdata;
               default: ;
            endcase
         end
         isr_q <= (isr_q & ~w1c) | (in_s ^ in_prev);
      end
   end

   // Registered active-low interrupt
   always_ff @(posedge CLK) begin
      if (!RST_N) int_n_q <= 1'b1;
      else        int_n_q <= ~|(isr_q & ie_q);
   end

   assign SPI_INT_N = int_n_q;
   assign IO_OUT    = out_q;
   assign IO_OE     = dir_q;
   assign SPI_MISO  = ~SPI_NSS & (state == DATA) & cmd_q[7] & tx_sr[15];

endmodule

// File: tb/tb_io16_spi_slave.sv
// Randomized bench for io16_spi_slave with reference model and scoreboard.
// Latency: checks follow frame completion or a fixed CLK count after pin toggles.
// Backpressure: not applicable; bench drives SPI as master.
module tb_io16_spi_slave;

   localparam int HALF = 8;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        SPI_CLK = 1'b0;
   logic        SPI_MOSI = 1'b0;
   logic        SPI_NSS = 1'b1;
   logic [15:0] IO_IN = 16'h0000;
   logic        SPI_MISO, SPI_INT_N;
   logic [15:0] IO_OUT, IO_OE;

   always #5 CLK = ~CLK;

   io16_spi_slave #(.ID_VALUE(16'h1016), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
      .SPI_NSS(SPI_NSS), .SPI_MISO(SPI_MISO), .SPI_INT_N(SPI_INT_N),
      .IO_IN(IO_IN), .IO_OUT(IO_OUT), .IO_OE(IO_OE)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard queues
   logic [15:0] exp_q[$];
   string       name_q[$];
   logic [15:0] obs_q[$];

   // reference register state
   logic [15:0] m_out = 0, m_dir = 0, m_ie = 0, m_isr = 0;

   task automatic sb_expect(input string name, input logic [15:0] v);
      exp_q.push_back(v);
      name_q.push_back(name);
   endtask

   task automatic sb_observe(input logic [15:0] v);
      obs_q.push_back(v);
   endtask

   // monitor: pops and compares whenever an observation appears
   initial begin
      logic [15:0] e, o;
      string       nm;
      forever begin
         @(negedge CLK);
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_obs: got %h required nothing", o);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (o !== e) begin
                  n_fail++;
                  $display("FAIL %s: got %h required %h", nm, o, e);
               end
            end
         end
      end
   end

   function automatic logic [15:0] model_read(input logic [6:0] a);
      case (a)
         7'h00: return m_out;
         7'h01: return m_dir;
         7'h02: return IO_IN;
         7'h03: return m_ie;
         7'h04: return m_isr;
         7'h05: return 16'h1016;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check_now(input string name, input logic [15:0] e, input logic [15:0] a);
      sb_expect(name, e);
      sb_observe(a);
   endtask

   task automatic check_io();
      check_now("io_out", m_out, IO_OUT);
      check_now("io_oe", m_dir, IO_OE);
      check_now("int_n", {15'd0, ~|(m_isr & m_ie)}, {15'd0, SPI_INT_N});
   endtask

   // SPI master: MSB first, mode 0; toggles IO_IN by tmask together with rise tidx
   task automatic spi_frame(input logic rd, input logic [6:0] addr, input logic [15:0] wd,
                            input int nbits, input int tidx, input logic [15:0] tmask,
                            input logic [15:0] exp_rd);
      logic [23:0] fr;
      logic [15:0] rdat;
      logic        quiet;
      fr    = {rd, addr, wd};
      rdat  = 16'h0000;
      quiet = 1'b0;
      sb_expect("miso_quiet", 16'h0000);
      if (rd) sb_expect("read_data", exp_rd);
      @(negedge CLK);
      SPI_NSS = 1'b0;
      repeat (HALF) @(negedge CLK);
      for (int i = 0; i < nbits; i++) begin
         SPI_MOSI = (i < 24) ? fr[23-i] : 1'($urandom_range(0, 1));
         repeat (HALF) @(negedge CLK);
         if (rd && i >= 8 && i < 24) rdat[23-i] = SPI_MISO;
         else quiet = quiet | SPI_MISO;
         SPI_CLK = 1'b1;
         if (i + 1 == tidx) IO_IN = IO_IN ^ tmask;
         repeat (HALF) @(negedge CLK);
         SPI_CLK = 1'b0;
      end
      repeat (HALF) @(negedge CLK);
      SPI_NSS = 1'b1;
      repeat (HALF) @(negedge CLK);
      sb_observe({15'd0, quiet});
      if (rd) sb_observe(rdat);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [15:0] d, input int nbits = 24,
                           input int tidx = 0, input logic [15:0] tmask = 16'h0);
      spi_frame(1'b0, a, d, nbits, tidx, tmask, 16'h0);
      if (tidx > 0 && tidx < 24 && tidx <= nbits) m_isr = m_isr | tmask;
      if (nbits >= 24) begin
         case (a)
            7'h00: m_out = d;
            7'h01: m_dir = d;
            7'h03: m_ie  = d;
            7'h04: m_isr = m_isr & ~d;
            default: ;
         endcase
      end
      if (tidx >= 24 && tidx <= nbits) m_isr = m_isr | tmask;
      check_io();
   endtask

   task automatic do_read(input logic [6:0] a, input int tidx = 0, input logic [15:0] tmask = 16'h0);
      logic [15:0] e;
      e = model_read(a);
      spi_frame(1'b1, a, 16'h0, 24, tidx, tmask, e);
      if (tidx > 0) m_isr = m_isr | tmask;
      check_io();
   endtask

   // pin change; interrupt must respond within 4 CLK
   task automatic set_pins(input logic [15:0] v);
      @(negedge CLK);
      m_isr = m_isr | (IO_IN ^ v);
      IO_IN = v;
      repeat (4) @(negedge CLK);
      check_now("int_latency", {15'd0, ~|(m_isr & m_ie)}, {15'd0, SPI_INT_N});
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      logic [6:0] a;
      int         bound;
      // reset
      RST_N = 1'b0;
      repeat (4) @(negedge CLK);
      check_now("rst_io_oe", 16'h0000, IO_OE);
      check_now("rst_io_out", 16'h0000, IO_OUT);
      check_now("rst_int_n", 16'h0001, {15'd0, SPI_INT_N});
      check_now("rst_miso", 16'h0000, {15'd0, SPI_MISO});
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);
      do_read(7'h05);
      do_read(7'h04);

      // write / readback
      do_write(7'h01, 16'h00FF);
      do_write(7'h00, 16'hA5C3);
      do_read(7'h01);
      do_read(7'h00);

      // interrupt
      do_write(7'h03, 16'h0001);
      set_pins(16'h0001);
      do_read(7'h04);
      set_pins(16'h0003);
      do_read(7'h04);
      do_write(7'h04, 16'h0001);
      do_read(7'h04);

      // set/clear collision on ISR[0]
      do_write(7'h04, 16'h0001, 24, 24, 16'h0001);
      do_read(7'h04);
      do_write(7'h04, 16'hFFFF);

      // aborted frame, then a normal one
      do_write(7'h00, 16'h1234, 20);
      do_read(7'h00);
      do_write(7'h00, 16'h1234);

      // bad address and long frame
      do_write(7'h7F, 16'hFFFF);
      do_read(7'h7F);
      do_write(7'h03, 16'h00F0, 32);
      do_read(7'h03);

      // read value is captured at the end of the command byte
      do_read(7'h02, 12, 16'h8000);
      do_read(7'h04);

      // randomized traffic against the model
      for (int k = 0; k < 30; k++) begin
         a = ($urandom_range(0, 9) > 7) ? 7'h7F : 7'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0: do_write(a, 16'($urandom));
            1: do_read(a);
            default: set_pins(16'($urandom));
         endcase
      end
      check_now("final_miso", 16'h0000, {15'd0, SPI_MISO});

      bound = 0;
      while (obs_q.size() > 0 && bound < 100) begin
         @(negedge CLK);
         bound++;
      end
      @(negedge CLK);
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d obs %0d exp left required 0", obs_q.size(), exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/io16_spi_slave.md
# io16_spi_slave

SPI register slave on the IO16 module card. It terminates the IO16 SPI bus after the CPLD steers it by chip select, which makes it the stage directly downstream of the CPLD's io16 passthrough. It exposes 16 bidirectional IO lines through a small register file and drives the card's active-low interrupt line back through the CPLD. All SPI inputs are oversampled in the CLK domain; no logic runs on SPI_CLK.

## Interface
Parameters:
- ID_VALUE, 16'h1016, constant returned by the ID register.
- SYNC_STAGES, 2, synchronizer depth on SPI_CLK, SPI_MOSI, SPI_NSS and IO_IN (minimum 2).

Ports:
- CLK  in  1  system clock; frequency must be at least 8× the SPI_CLK frequency.
- RST_N  in  1  synchronous active-low reset, sampled on rising CLK.
- SPI_CLK  in  1  SPI clock from the CPLD; mode 0 (CPOL=0, CPHA=0).
- SPI_MOSI  in  1  master data, MSB first.
- SPI_NSS  in  1  active-low frame select.
- SPI_MISO  out  1  slave data; driven 0 whenever NSS is high.
- SPI_INT_N  out  1  active-low interrupt to the CPLD.
- IO_IN  in  16  pin input levels, asynchronous.
- IO_OUT  out  16  pin output levels.
- IO_OE  out  16  pin output enables; 1 = output.

## Operation
- Frame format: 24 bits, MSB first.
  - Bits 23:16 are the command: bit 23 = R/nW (1 = read), bits 22:16 = address.
  - Bits 15:0 are data.
- Register map (16-bit):
  - 0x00 OUT: rw; drives IO_OUT.
  - 0x01 DIR: rw; drives IO_OE.
  - 0x02 IN: ro; synchronized IO_IN.
  - 0x03 IE: rw; interrupt enable.
  - 0x04 ISR: status; write-1-to-clear.
  - 0x05 ID: ro; ID_VALUE.
  - Any other address reads 0x0000 and ignores writes.
- Frame FSM states:
  - IDLE: waits for the NSS falling edge, then clears the bit counter and goes to CMD.
  - CMD: shifts 8 bits on SCK rising edges. After bit 8, if R/nW=1, latches the addressed register into the TX shifter. Goes to DATA.
  - DATA: shifts 16 bits. On the 24th rising edge: if the frame is a write, commits the data and goes to DONE; if it is a read, goes to DONE directly.
  - DONE: ignores further SCK edges and waits for NSS high, then returns to IDLE.
- NSS rising in any state returns the FSM to IDLE. A frame aborted before bit 24 performs no write.
- MISO:
  - Driven 0 during CMD and for writes.
  - On reads, TX shifter bit 15 is presented, and the shifter advances on each detected SCK falling edge.
  - The first data bit is valid before the 9th SCK rising edge.
- Change detection: an edge on synchronized IN[i] (previous value differs from current) sets ISR[i], irrespective of IE and DIR.
- Simultaneous W1C and set on the same ISR bit in the same CLK: set wins.
- Reading ISR does not clear it.
- SPI_INT_N = ~|(ISR & IE), registered.
- Reset values (RST_N=0): OUT=0, DIR=0, IE=0, ISR=0, FSM=IDLE, SPI_MISO=0, SPI_INT_N=1, IO_OUT=0, IO_OE=0. The IN previous-sample register loads the current synchronized value so that reset exit produces no spurious edge. Reset asserted mid-frame abandons the frame.

## Timing
- SCK and NSS edges are detected SYNC_STAGES+1 CLK after the pin changes.
- SPI_MISO updates 1 CLK after a falling edge is detected. With SYNC_STAGES=2, that is 4 CLK after the SCK fall, which is inside half an SCK period at the 8× ratio.
- Write commit:
  - The register updates 1 CLK after the 24th rising edge is detected.
  - IO_OUT and IO_OE follow the register directly, with no extra delay.
- Interrupt path: IO_IN change → ISR bit set after SYNC_STAGES+1 CLK → SPI_INT_N low 1 CLK later.
- A read captures the register value at the end of the command byte. Later changes do not alter the frame in flight.

## Test plan
- Reset: hold RST_N=0 for 4 CLK → IO_OE=0x0000, IO_OUT=0x0000, SPI_INT_N=1, SPI_MISO=0. Read 0x05 → 0x1016.
- Write/readback: write 0x01=0x00FF, then 0x00=0xA5C3 → IO_OE=0x00FF, IO_OUT=0xA5C3 one CLK after the 24th edge. Reading both registers returns those values.
- Interrupt: IE=0x0001, toggle IO_IN[0] → ISR=0x0001 and SPI_INT_N=0 within 4 CLK. Toggle IO_IN[1] → ISR=0x0003 with INT_N unchanged. Write 0x04=0x0001 → ISR=0x0002, INT_N=1.
- Set/clear collision: toggle IO_IN[0] in the same CLK as the W1C commit of bit 0 → ISR[0] stays 1.
- Aborted frame: raise NSS after 20 bits of a write to 0x00=0x1234 → OUT is unchanged. The next full frame decodes correctly.
- Bad address / long frame: write 0x7F=0xFFFF → no register changes, and reading 0x7F returns 0x0000. A frame of 32 SCK cycles on a write to 0x03 commits only the first 16 data bits.
